imem_stream_loader: RTL
=======================

Name: imem_stream_loader

Overview:
- Parametrised instruction memory with a built-in streaming loader and a CPU fetch port; the next generation of the single-port-write, dual-port-read instruction store.
- Words are loaded as a valid/ready stream with auto-incrementing addresses from a programmable base, and a running XOR checksum is kept over the loaded words.
- The fetch port is either combinational or registered, selected by parameter, and is blocked while a load is in progress.
- Sits between the host/UART loader and the processor fetch stage.

Parameters:
- ADDR_W, 10, word-address width; depth is 2**ADDR_W words.
- DATA_W, 32, instruction word width.
- READ_LAT, 1, fetch latency: 0 = combinational read, 1 = registered read. Any other value is illegal and must be flagged by an elaboration-time check.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- load_base  in  ADDR_W  first write address, captured with load_start.
- load_len  in  ADDR_W+1  number of words to load, captured with load_start.
- load_data  in  DATA_W  stream word.
- load_valid  in  1  stream word valid.
- load_ready  out  1  loader accepts a word this cycle.
- load_done  out  1  one-cycle pulse when a load completes.
- load_csum  out  DATA_W  XOR of all words accepted in the current or last load.
- busy  out  1  high while in LOAD or DONE.
- fetch_en  in  1  fetch request.
- fetch_addr  in  ADDR_W  fetch word address.
- fetch_data  out  DATA_W  fetched instruction.
- fetch_valid  out  1  fetch_data is valid.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, load_ready=0, load_done=0, load_csum=0, busy=0, fetch_valid=0, fetch_data=0 (READ_LAT=1). Memory array is not reset; its contents survive reset.

State machine:
- IDLE:
  - load_start=1 captures load_base into the write pointer, load_len into the remaining-word count, and clears load_csum.
  - Goes to DONE if load_len==0, otherwise to LOAD.
- LOAD:
  - load_ready=1 combinationally (a function of state only).
  - Transfer occurs on a cycle with load_valid && load_ready: write load_data to mem[wptr]; wptr+1 mod 2**ADDR_W (wrap-around past the top address is legal); load_csum ^= load_data; count-1.
  - Goes to DONE on the transfer that takes the count to 0.
  - load_valid low leaves the state unchanged, with no timeout.
- DONE: load_done=1 for exactly this cycle; load_ready=0; next state is IDLE.

Handshake and status:
- load_start outside IDLE is ignored.
- load_len > 2**ADDR_W is clamped to 2**ADDR_W.
- busy = (state != IDLE).

Fetch port:
- READ_LAT=0: fetch_data = mem[fetch_addr] combinationally; fetch_valid = fetch_en && !busy.
- READ_LAT=1: on each clk edge, fetch_valid <= fetch_en && !busy. fetch_data <= mem[fetch_addr] only when fetch_en && !busy; otherwise fetch_data holds.
- While busy, fetch_valid=0; fetch requests are dropped, not queued.
- Read of an address written in the same cycle cannot occur, because writes only happen while busy.

Reset mid-load:
- Returns to IDLE immediately; load_done is not pulsed; load_csum is cleared.
- Words already written remain in memory.

Test Plan:
1. Reset, then load_start with base=0, len=4, words 0x11,0x22,0x44,0x88 with load_valid held high -> four transfers on consecutive cycles; load_done pulses the cycle after the 4th transfer; load_csum=0xFF; busy deasserts with load_done.
2. After test 1, READ_LAT=1, fetch_en=1, fetch_addr=2 -> next cycle fetch_data=0x44, fetch_valid=1. READ_LAT=0 -> same cycle.
3. base=0x3FE, len=4, words A,B,C,D -> mem[0x3FE]=A, mem[0x3FF]=B, mem[0x000]=C, mem[0x001]=D.
4. load_valid toggled 1,0,0,1,1 during a len=3 load with fetch_en held high -> exactly 3 writes; fetch_valid=0 throughout busy; fetch_valid=1 again the cycle after returning to IDLE (READ_LAT=1).
5. len=0 -> DONE on the next cycle, load_done pulses once, no memory write, load_csum=0. Second load_start asserted during DONE -> ignored.
6. rst_n low after 2 of 5 words -> busy=0, load_ready=0, load_csum=0 asynchronously; both written words readable after release; no load_done pulse.

Source files
------------

// File: rtl/imem_stream_loader.sv
// Instruction memory with a streaming valid/ready loader, a running XOR checksum
// and a CPU fetch port that is blocked while a load is in progress.
`timescale 1ns/1ps
module imem_stream_loader #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              load_done,
  output logic [DATA_W-1:0] load_csum,
  output logic              busy,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid
);

  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  generate
    if (READ_LAT != 0 && READ_LAT != 1) begin : g_bad_read_lat
      $error("imem_stream_loader: READ_LAT must be 0 or 1");
    end
  endgenerate

  function automatic logic [DATA_W-1:0] csum_next(input logic [DATA_W-1:0] csum,
                                                  input logic [DATA_W-1:0] word);
    return csum ^ word;
  endfunction

  state_e              state_q;
  logic [ADDR_W-1:0]   wptr_q;
  logic [ADDR_W:0]     count_q;
  logic [DATA_W-1:0]   csum_q;
  logic [ADDR_W:0]     len_clamped_s;
  logic                xfer_s;
  logic                busy_s;
  logic                fetch_ok_s;
  logic [DATA_W-1:0]   mem_q [0:(2**ADDR_W)-1];

  assign len_clamped_s = (load_len > DEPTH_L) ? DEPTH_L : load_len;
  assign xfer_s        = (state_q == ST_LOAD) && load_valid;
  assign busy_s        = (state_q != ST_IDLE);
  assign fetch_ok_s    = fetch_en && !busy_s;

  assign load_ready = (state_q == ST_LOAD);
  assign load_done  = (state_q == ST_DONE);
  assign load_csum  = csum_q;
  assign busy       = busy_s;

  // Loader FSM: write pointer, remaining-word count and checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wptr_q  <= {ADDR_W{1'b0}};
      count_q <= {(ADDR_W+1){1'b0}};
      csum_q  <= {DATA_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_start) begin
            wptr_q  <= load_base;
            count_q <= len_clamped_s;
            csum_q  <= {DATA_W{1'b0}};
            state_q <= (load_len == {(ADDR_W+1){1'b0}}) ? ST_DONE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (load_valid) begin
            wptr_q  <= wptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            count_q <= count_q - {{ADDR_W{1'b0}}, 1'b1};
            csum_q  <= csum_next(csum_q, load_data);
            if (count_q == {{ADDR_W{1'b0}}, 1'b1}) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Memory array is deliberately not reset so a program survives rst_n.
  always_ff @(posedge clk) begin
    if (xfer_s) begin
      mem_q[wptr_q] <= load_data;
    end
  end

  generate
    if (READ_LAT == 0) begin : g_comb_read
      assign fetch_data  = mem_q[fetch_addr];
      assign fetch_valid = fetch_ok_s;
    end else begin : g_reg_read
      logic [DATA_W-1:0] fdata_q;
      logic              fvalid_q;

      // Registered fetch; data holds when no fetch is accepted.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fvalid_q <= 1'b0;
          fdata_q  <= {DATA_W{1'b0}};
        end else begin
          fvalid_q <= fetch_ok_s;
          if (fetch_ok_s) begin
            fdata_q <= mem_q[fetch_addr];
          end
        end
      end

      assign fetch_data  = fdata_q;
      assign fetch_valid = fvalid_q;
    end
  endgenerate

endmodule
